reset_sequencer: RTL and testbench

//   Ordered reset-release controller for up to NumDomains downstream reset domains.

---
 rtl/reset_sequencer_if.sv | 33 +++
 rtl/reset_sequencer.sv | 174 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer bundle: per-domain ready inputs, software restart request,
// and the sequenced reset/status outputs. The sequencer itself uses the
// master modport; the reset-domain side uses the slave modport.
interface reset_sequencer_if #(
    parameter int NumDomains = 4
);
    localparam int CurW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    logic [NumDomains-1:0] domain_ready;
    logic                  sw_rst_req;
    logic [NumDomains-1:0] domain_rst;
    logic [CurW-1:0]       cur_domain;
    logic                  all_released;
    logic                  timeout_err;

    modport master (
        input  domain_ready,
        input  sw_rst_req,
        output domain_rst,
        output cur_domain,
        output all_released,
        output timeout_err
    );

    modport slave (
        output domain_ready,
        output sw_rst_req,
        input  domain_rst,
        input  cur_domain,
        input  all_released,
        input  timeout_err
    );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller. Domains are released one at a time,
// lowest index first, with GapCycles between a domain's ready and the next
// release. Each released domain must report ready within TimeoutCycles or
// it is put back into reset and a sticky timeout flag is raised. A one-cycle
// sw_rst_req replays the whole sequence from the beginning.
module reset_sequencer #(
    parameter int NumDomains    = 4,
    parameter int GapCycles     = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    reset_sequencer_if.master    bus
);

    localparam int CurW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam int MaxCyc = (GapCycles > TimeoutCycles) ? GapCycles : TimeoutCycles;
    localparam int CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);
    localparam logic [CntW-1:0] ToutLast = CntW'(TimeoutCycles - 1);
    localparam logic [CurW-1:0] LastIdx  = CurW'(NumDomains - 1);

    typedef enum logic [1:0] {
        ST_GAP,
        ST_WAIT,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CntW-1:0]       r_gap_cnt;
    logic [CntW-1:0]       w_gap_cnt_nxt;
    logic [CntW-1:0]       r_tout_cnt;
    logic [CntW-1:0]       w_tout_cnt_nxt;
    logic [CurW-1:0]       r_cur;
    logic [CurW-1:0]       w_cur_nxt;
    logic [NumDomains-1:0] r_domain_rst;
    logic [NumDomains-1:0] w_domain_rst_nxt;
    logic                  r_all_released;
    logic                  w_all_released_nxt;
    logic                  r_timeout_err;
    logic                  w_timeout_err_nxt;

    logic                  w_ready_cur;
    logic                  w_gap_end;
    logic                  w_tout_end;
    logic                  w_last_dom;

    // Only the domain currently being sequenced is observed.
    assign w_ready_cur = bus.domain_ready[r_cur];
    assign w_gap_end   = (r_gap_cnt == GapLast);
    assign w_tout_end  = (r_tout_cnt == ToutLast);
    assign w_last_dom  = (r_cur == LastIdx);

    // State, counters and registered outputs; async reset restores the start of the sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_GAP;
            r_gap_cnt      <= '0;
            r_tout_cnt     <= '0;
            r_cur          <= '0;
            r_domain_rst   <= '1;
            r_all_released <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_tout_cnt     <= w_tout_cnt_nxt;
            r_cur          <= w_cur_nxt;
            r_domain_rst   <= w_domain_rst_nxt;
            r_all_released <= w_all_released_nxt;
            r_timeout_err  <= w_timeout_err_nxt;
        end
    end

    // Next state, counters and domain index; a software restart overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_tout_cnt_nxt = r_tout_cnt;
        w_cur_nxt      = r_cur;

        if (bus.sw_rst_req) begin
            w_state_nxt    = ST_GAP;
            w_gap_cnt_nxt  = '0;
            w_tout_cnt_nxt = '0;
            w_cur_nxt      = '0;
        end else begin
            case (r_state)
                ST_GAP: begin
                    if (w_gap_end) begin
                        w_state_nxt    = ST_WAIT;
                        w_gap_cnt_nxt  = '0;
                        w_tout_cnt_nxt = '0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_ready_cur) begin
                        if (w_last_dom) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt   = ST_GAP;
                            w_gap_cnt_nxt = '0;
                            w_cur_nxt     = r_cur + 1'b1;
                        end
                    end else if (w_tout_end) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_tout_cnt_nxt = r_tout_cnt + 1'b1;
                    end
                end
                ST_DONE:  w_state_nxt = ST_DONE;
                ST_FAULT: w_state_nxt = ST_FAULT;
                default:  w_state_nxt = ST_GAP;
            endcase
        end
    end

    // Next values of the registered outputs, decoded from the same transitions.
    always_comb begin
        w_domain_rst_nxt   = r_domain_rst;
        w_all_released_nxt = r_all_released;
        w_timeout_err_nxt  = r_timeout_err;

        if (bus.sw_rst_req) begin
            w_domain_rst_nxt   = '1;
            w_all_released_nxt = 1'b0;
            w_timeout_err_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_GAP: begin
                    if (w_gap_end) begin
                        w_domain_rst_nxt[r_cur] = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (w_ready_cur) begin
                        if (w_last_dom) begin
                            w_all_released_nxt = 1'b1;
                        end
                    end else if (w_tout_end) begin
                        // Only the stuck domain goes back into reset; earlier ones stay released.
                        w_domain_rst_nxt[r_cur] = 1'b1;
                        w_timeout_err_nxt       = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_domain_rst_nxt = '0;
                end
                default: begin
                    w_domain_rst_nxt = r_domain_rst;
                end
            endcase
        end
    end

    assign bus.domain_rst   = r_domain_rst;
    assign bus.cur_domain   = r_cur;
    assign bus.all_released = r_all_released;
    assign bus.timeout_err  = r_timeout_err;

    // Structural invariants of the sequence.
    a_done_released : assert property (@(posedge clk) disable iff (rst)
        r_all_released |-> (r_domain_rst == '0));
    a_done_no_err : assert property (@(posedge clk) disable iff (rst)
        r_timeout_err |-> !r_all_released);
    a_fault_flag : assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_FAULT) |-> r_timeout_err);

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer. A timeline model computes, from the
// release/ready/timeout rules, the edge at which each output change must
// appear; a monitor pops these expectations whenever the outputs change.
module tb_reset_sequencer;

    localparam int N     = 4;
    localparam int GAP   = 16;
    localparam int TOUT  = 1024;
    localparam int BIG   = 100000;
    localparam int NEVER = 400000;
    localparam int NRUNS = 16;

    typedef struct packed {
        logic [N-1:0] r;
        logic [1:0]   c;
        logic         a;
        logic         e;
    } snap_t;

    typedef struct {
        int    t;
        snap_t s;
    } ev_t;

    localparam snap_t RST_SNAP = '{r: '1, c: '0, a: 1'b0, e: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    reset_sequencer_if #(.NumDomains(N)) ifc ();

    reset_sequencer #(
        .NumDomains   (N),
        .GapCycles    (GAP),
        .TimeoutCycles(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    ev_t   pq[$];
    ev_t   sb[$];
    snap_t last_exp = RST_SNAP;
    int    dly[N];
    int    rel_at[N];
    int    wdone_at[N];
    int    rdy_from[N];
    int    checks = 0;
    int    failures = 0;
    bit    end_req = 1'b0;
    bit    end_ack = 1'b0;

    // Timeline of one sequence starting from reset values at edge b.
    function automatic void make_plan(int b);
        snap_t s;
        int    t;
        int    k;
        bit    stop;
        pq.delete();
        s    = RST_SNAP;
        t    = b + GAP;
        stop = 1'b0;
        for (int i = 0; i < N; i++) begin
            rel_at[i]   = NEVER;
            wdone_at[i] = NEVER;
            rdy_from[i] = NEVER;
        end
        for (int i = 0; i < N && !stop; i++) begin
            rel_at[i] = t;
            s.r[i]    = 1'b0;
            pq.push_back('{t, s});
            k           = (dly[i] < 1) ? 1 : dly[i];
            rdy_from[i] = t + dly[i];
            if (k > TOUT) begin
                wdone_at[i] = t + TOUT;
                s.r[i]      = 1'b1;
                s.e         = 1'b1;
                pq.push_back('{t + TOUT, s});
                stop = 1'b1;
            end else begin
                wdone_at[i] = t + k;
                if (i == N - 1) s.a = 1'b1;
                else            s.c = 2'(i + 1);
                pq.push_back('{t + k, s});
                t = t + k + GAP;
            end
        end
    endfunction

    // Expectations that happen before the restart edge x, then the restart itself.
    function automatic void commit(int x);
        foreach (pq[j]) begin
            if (pq[j].t < x) begin
                sb.push_back(pq[j]);
                last_exp = pq[j].s;
            end
        end
        if (x < NEVER && last_exp != RST_SNAP) begin
            sb.push_back('{x, RST_SNAP});
            last_exp = RST_SNAP;
        end
    endfunction

    // Ready for edge e: follows the plan while a domain is being waited on, random otherwise.
    function automatic void drive_ready(int e);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) begin
            if (e > rel_at[i] && e <= wdone_at[i]) v[i] = (e >= rdy_from[i]);
            else                                   v[i] = 1'($urandom_range(0, 1));
        end
        ifc.domain_ready = v;
    endfunction

    task automatic step();
        @(negedge clk);
        drive_ready(cyc + 1);
    endtask

    // Monitor: every observed output change must match the next expectation.
    initial begin
        snap_t prev;
        snap_t cur;
        ev_t   ex;
        prev = RST_SNAP;
        forever begin
            @(negedge clk);
            cur = '{r: ifc.domain_rst, c: ifc.cur_domain, a: ifc.all_released, e: ifc.timeout_err};
            if (cur != prev) begin
                checks = checks + 1;
                if (sb.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_change cyc=%0d got rst=%b cur=%0d all=%b terr=%b, required no change",
                             cyc, cur.r, cur.c, cur.a, cur.e);
                end else begin
                    ex = sb.pop_front();
                    if (ex.t != cyc || ex.s != cur) begin
                        failures = failures + 1;
                        $display("FAIL output_event got cyc=%0d rst=%b cur=%0d all=%b terr=%b, required cyc=%0d rst=%b cur=%0d all=%b terr=%b",
                                 cyc, cur.r, cur.c, cur.a, cur.e, ex.t, ex.s.r, ex.s.c, ex.s.a, ex.s.e);
                    end
                end
                prev = cur;
            end
            if (end_req && !end_ack) begin
                checks = checks + 1;
                if (sb.size() != 0) begin
                    failures = failures + 1;
                    $display("FAIL pending_events got=%0d required=0 (next due cyc=%0d)", sb.size(), sb[0].t);
                end
                end_ack = 1'b1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int x;
        int kind;
        int last;
        int h;
        ifc.domain_ready = '0;
        ifc.sw_rst_req   = 1'b0;
        #1 rst = 1'b1;
        while (cyc < 2) step();
        rst = 1'b0;
        b   = 2;

        for (int r = 0; r < NRUNS; r++) begin
            while (cyc < b + 1) step();
            case (r)
                0, 2: dly = '{0, 0, 0, 0};
                1:    dly = '{0, 0, BIG, 0};
                3:    dly = '{3, 30, 2, 5};
                default: begin
                    for (int i = 0; i < N; i++) begin
                        dly[i] = int'($urandom_range(0, 45)) - 5;
                        if ($urandom_range(0, 15) == 0) dly[i] = BIG;
                    end
                end
            endcase
            make_plan(b);
            last = pq[$].t;

            // kind: 0 = run to completion, 1 = sw_rst_req at edge x, 2 = async rst after edge x
            case (r)
                0, 1: begin kind = 1; x = last + 20; end
                2:    begin kind = 1; x = wdone_at[0] + 8; end
                3:    begin kind = 2; x = rel_at[1] + 10; end
                default: begin
                    if (r == NRUNS - 1) begin
                        kind = 0;
                        x    = NEVER;
                    end else begin
                        case ($urandom_range(0, 2))
                            0: begin kind = 1; x = last + int'($urandom_range(3, 30)); end
                            1: begin kind = 1; x = b + 3 + int'($urandom_range(0, 32'(last + 2 - b))); end
                            default: begin kind = 2; x = b + 3 + int'($urandom_range(0, 32'(last + 2 - b))); end
                        endcase
                    end
                end
            endcase
            commit(x);

            if (kind == 0) begin
                while (cyc < last + 30) step();
            end else if (kind == 1) begin
                while (cyc < x - 1) step();
                ifc.sw_rst_req = 1'b1;
                step();
                ifc.sw_rst_req = 1'b0;
                b = x;
            end else begin
                while (cyc < x - 1) step();
                @(posedge clk);
                #2 rst = 1'b1;
                step();
                h = int'($urandom_range(1, 3));
                while (cyc < x + h) step();
                rst = 1'b0;
                b   = x + h;
            end
        end

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) step();
        if (!end_ack) $display("FAIL end_handshake got=0 required=1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
